// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory
// and loads the IF/ID register; handles stall, redirect/flush, boot and halt.
module fetch_stage #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_target,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   ifid_valid,
  output logic [INS_W-1:0]       ifid_inst,
  output logic [INS_ADDRESS-1:0] ifid_pc,
  output logic [INS_ADDRESS-1:0] ifid_pc4,
  output logic                   halted,
  output logic                   misalign_err
);

  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);
  localparam logic [INS_W-1:0] EBREAK = INS_W'(32'h0010_0073);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INS_W-1:0]       inst_q, inst_d;
  logic [INS_ADDRESS-1:0] ipc_q, ipc_d;
  logic [INS_ADDRESS-1:0] ipc4_q, ipc4_d;
  logic                   halted_q, halted_d;
  logic                   mis_q, mis_d;

  logic [INS_ADDRESS-1:0] tgt_pc;
  logic [INS_ADDRESS-1:0] pc_inc;
  logic                   tgt_mis;

  assign tgt_pc  = {redirect_target[INS_ADDRESS-1:2], 2'b00};
  assign tgt_mis = |redirect_target[1:0];
  assign pc_inc  = pc_q + INS_ADDRESS'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) begin
          pc_d  = tgt_pc;
          mis_d = tgt_mis;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d    = tgt_pc;
          valid_d = 1'b0;
          mis_d   = tgt_mis;
        end else if (!stall) begin
          inst_d  = imem_rd;
          ipc_d   = pc_q;
          ipc4_d  = pc_inc;
          valid_d = 1'b1;
          // EBREAK is handed to decode but the PC stays on it
          if (imem_rd == EBREAK) state_d = HALT;
          else pc_d = pc_inc;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = tgt_pc;
          valid_d = 1'b0;
          mis_d   = tgt_mis;
          state_d = RUN;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= NOP;
      ipc_q    <= '0;
      ipc4_q   <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  assign imem_ra      = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_inst    = inst_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc4     = ipc4_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_target = '0;
  logic [8:0]  imem_ra;
  logic [31:0] imem_rd;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [8:0]  ifid_pc;
  logic [8:0]  ifid_pc4;
  logic        halted;
  logic        misalign_err;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  int          m_pc, m_mode, m_ipc, m_ipc4;
  bit          m_valid, m_mis;
  logic [31:0] m_inst;

  fetch_stage #(
    .INS_ADDRESS(9),
    .INS_W(32),
    .RESET_PC(9'h000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_ra(imem_ra),
    .imem_rd(imem_rd),
    .ifid_valid(ifid_valid),
    .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4),
    .halted(halted),
    .misalign_err(misalign_err)
  );

  assign imem_rd = mem[imem_ra[8:2]];

  always #5 clk = ~clk;

  logic [61:0] dut_vec;
  assign dut_vec = {imem_ra, ifid_valid, ifid_inst, ifid_pc,
                    ifid_pc4, halted, misalign_err};

  function automatic logic [61:0] exp_vec();
    return {9'(m_pc), m_valid, m_inst, 9'(m_ipc), 9'(m_ipc4),
            m_mode == 2, m_mis};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mode = 0; m_valid = 0; m_inst = NOP;
    m_ipc = 0; m_ipc4 = 0; m_mis = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  // Model mode: 0 boot, 1 run, 2 halt. Next state is worked out from the
  // inputs and the model's own memory view before the edge.
  task automatic step();
    int npc = m_pc, nmode = m_mode, nipc = m_ipc, nipc4 = m_ipc4;
    bit nvalid = m_valid, nmis = 0;
    logic [31:0] ninst = m_inst;
    int tgt = int'(redirect_target);
    if (m_mode == 0) begin
      nmode = 1;
      if (redirect_valid) begin
        npc = tgt - tgt % 4;
        nmis = (tgt % 4) != 0;
      end
    end else if (redirect_valid) begin
      npc = tgt - tgt % 4;
      nmis = (tgt % 4) != 0;
      nvalid = 0;
      nmode = 1;
    end else if (m_mode == 2) begin
      if (!stall) nvalid = 0;
    end else if (!stall) begin
      ninst = mem[m_pc / 4];
      nipc = m_pc;
      nipc4 = (m_pc + 4) % 512;
      nvalid = 1;
      if (ninst == EBREAK) nmode = 2;
      else npc = (m_pc + 4) % 512;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_mode = nmode; m_ipc = nipc; m_ipc4 = nipc4;
    m_valid = nvalid; m_mis = nmis; m_inst = ninst;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    do_reset();
    checks++;
    if (dut_vec !== {9'h000, 1'b0, NOP, 9'h000, 9'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", dut_vec,
               {9'h000, 1'b0, NOP, 9'h000, 9'h000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_boot_fetch();
    step();
    checks++;
    if ({ifid_valid, imem_ra} !== {1'b0, 9'h000}) begin
      errors++;
      $display("FAIL boot_bubble got v=%b ra=%h want v=0 ra=000",
               ifid_valid, imem_ra);
    end
    step();
    checks++;
    if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc4, imem_ra} !==
        {1'b1, 32'h0010_0093, 9'h000, 9'h004, 9'h004}) begin
      errors++;
      $display("FAIL first_fetch got v=%b i=%h pc=%h pc4=%h ra=%h",
               ifid_valid, ifid_inst, ifid_pc, ifid_pc4, imem_ra);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL first_fetch_model got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_stall();
    logic [51:0] held;
    step();
    held = {ifid_valid, ifid_inst, ifid_pc, ifid_pc4};
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_ra !== 9'h008 ||
          {ifid_valid, ifid_inst, ifid_pc, ifid_pc4} !== held) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got ra=%h ifid=%h want ra=008 ifid=%h",
                 i, imem_ra, {ifid_valid, ifid_inst, ifid_pc, ifid_pc4}, held);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({ifid_pc, imem_ra} !== {9'h008, 9'h00C}) begin
      errors++;
      $display("FAIL stall_release got pc=%h ra=%h want pc=008 ra=00c",
               ifid_pc, imem_ra);
    end
  endtask

  task automatic test_redirect_stall();
    int n = 0;
    while (m_pc != 'h30 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (m_pc != 'h30 || imem_ra !== 9'h030) begin
      errors++;
      $display("FAIL reach_030 got ra=%h want 030", imem_ra);
    end
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 9'h054;
    step();
    checks++;
    if ({imem_ra, ifid_valid, misalign_err} !== {9'h054, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL redir_stall got ra=%h v=%b mis=%b want ra=054 v=0 mis=0",
               imem_ra, ifid_valid, misalign_err);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 9'h054, mem[21]}) begin
      errors++;
      $display("FAIL redir_capture got v=%b pc=%h i=%h want v=1 pc=054 i=%h",
               ifid_valid, ifid_pc, ifid_inst, mem[21]);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_target = 9'h056;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_ra, misalign_err} !== {9'h054, 1'b1}) begin
      errors++;
      $display("FAIL misalign_pulse got ra=%h mis=%b want ra=054 mis=1",
               imem_ra, misalign_err);
    end
    step();
    checks++;
    if (misalign_err !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL misalign_clear got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_ebreak();
    mem[8] = EBREAK;
    redirect_valid = 1'b1;
    redirect_target = 9'h018;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({ifid_inst, ifid_valid, ifid_pc} !== {EBREAK, 1'b1, 9'h020}) begin
      errors++;
      $display("FAIL ebreak_capture got i=%h v=%b pc=%h want i=00100073 v=1 pc=020",
               ifid_inst, ifid_valid, ifid_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({halted, ifid_valid, imem_ra} !== {1'b1, 1'b0, 9'h020}) begin
        errors++;
        $display("FAIL halt_hold cyc=%0d got h=%b v=%b ra=%h want h=1 v=0 ra=020",
                 i, halted, ifid_valid, imem_ra);
      end
    end
    redirect_valid = 1'b1;
    redirect_target = 9'h100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({halted, imem_ra, ifid_valid} !== {1'b0, 9'h100, 1'b0}) begin
      errors++;
      $display("FAIL halt_exit got h=%b ra=%h v=%b want h=0 ra=100 v=0",
               halted, imem_ra, ifid_valid);
    end
    step();
    checks++;
    if ({ifid_valid, ifid_pc} !== {1'b1, 9'h100} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL halt_resume got=%h want=%h", dut_vec, exp_vec());
    end
    mem[8] = NOP;
  endtask

  task automatic test_random();
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom % 8 == 0) ? EBREAK : $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      stall = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 8) == 0;
      redirect_target = 9'($urandom);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    int n = 0;
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    do_reset();
    while (!(m_valid && m_ipc == 'h1FC) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if ({ifid_pc, ifid_pc4, imem_ra} !== {9'h1FC, 9'h000, 9'h000}) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h pc4=%h ra=%h want pc=1fc pc4=000 ra=000",
               ifid_pc, ifid_pc4, imem_ra);
    end
    for (int i = 0; i < 3; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({imem_ra, ifid_valid, halted} !== {9'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got ra=%h v=%b h=%b want ra=000 v=0 h=0",
               imem_ra, ifid_valid, halted);
    end
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_ebreak();
    test_random();
    test_wrap_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
